ram_burst_controller: RTL and testbench
=======================================

Name: ram_burst_controller

Overview:
Initiator that drives the single-port 20-bit x 1024 synchronous RAM. It accepts a burst command over a valid/ready interface and performs the burst in one of two directions:
- Write: streams words from an upstream valid/ready source into consecutive RAM addresses.
- Read: streams words from consecutive RAM addresses to a downstream valid/ready sink.
It hides the RAM's registered-address read latency and absorbs downstream backpressure, so a held-ready sink sees one word per cycle.

Parameters:
DATA_W, 20, RAM word width
ADDR_W, 10, RAM address width (depth 2**ADDR_W)

Ports:
clk  in  1  single clock, all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  controller idle, command accepted on valid&ready
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr  in  ADDR_W  burst start address
cmd_len  in  ADDR_W  burst length minus one (0 => 1 word, 1023 => 1024 words)
wr_valid  in  1  write-data word offered
wr_ready  out  1  write-data word accepted on valid&ready
wr_data  in  DATA_W  write-data word
rd_valid  out  1  read-data word available
rd_ready  in  1  sink accepts word on valid&ready
rd_data  out  DATA_W  read-data word
busy  out  1  burst in progress (state != IDLE)
done  out  1  one-cycle pulse after burst completes
ram_addr  out  ADDR_W  to RAM addr
ram_data  out  DATA_W  to RAM data
ram_we  out  1  to RAM we
ram_q  in  DATA_W  from RAM q

Behaviour:
- RAM contract:
  - ram_addr is sampled every rising edge; ram_q shows the word at that sampled address during the following cycle.
  - A write occurs at the edge where ram_we=1.
- Reset (rst_n=0, asynchronous):
  - State IDLE; index counter 0; read FIFO empty; in-flight flag 0.
  - Outputs: cmd_ready=0 while rst_n=0, then 1 after release; wr_ready=0; rd_valid=0; rd_data=0; busy=0; done=0; ram_we=0; ram_addr=0.
  - RAM contents are not touched.
- States: IDLE, WRITE, READ.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch base=cmd_addr, len=cmd_len, index=0.
  - Go to WRITE if cmd_write=1, else READ.
  - ram_we=0; ram_addr=0.
- Addressing:
  - ram_addr = (base + index) mod 2**ADDR_W, so the address wraps 1023 -> 0.
  - index increments by 1 per issued word.
- WRITE:
  - wr_ready=1; ram_data=wr_data; ram_we = wr_valid.
  - Each accepted beat writes at the current address and increments index.
  - wr_valid=0 stalls the burst with no write.
  - The beat with index==len returns the state to IDLE at that edge, and done=1 for the next cycle.
  - wr_ready=0 outside WRITE.
- READ:
  - Issue:
    - Drive ram_addr for the current index when all words are not yet issued and (fifo_count - pop + inflight) < 2, where pop = rd_valid&rd_ready.
    - On issue, index increments and inflight is set for one cycle.
  - Capture: the cycle after an issue, ram_q is pushed into the 2-entry read FIFO.
  - Output: rd_valid = FIFO non-empty; rd_data = FIFO head.
  - Latency: with the command accepted at edge E0, the first address is issued in the cycle after E0 and rd_valid rises after edge E2.
  - Throughput: with rd_ready held high, one word per cycle with no bubbles.
  - With rd_ready low, issue stops with at most 2 words buffered. No word is lost or duplicated.
  - Completion: after the last word pops with nothing in flight, the state returns to IDLE and done=1 for one cycle.
- General:
  - ram_we=0 in READ and IDLE.
  - cmd_valid while busy is ignored (cmd_ready=0).
  - A burst cannot be aborted except by reset. Reset mid-burst discards the FIFO and state immediately; RAM words already written stay written.
  - rd_valid stays asserted until accepted. rd_data is stable while rd_valid&!rd_ready.
  - The done pulse and cmd_ready=1 occur in the same cycle; a new command may be accepted in that cycle.

Test Plan:
1. Reset: assert rst_n=0 mid-idle -> all outputs 0 immediately; release -> cmd_ready=1, busy=0.
2. Write wrap-around: write cmd addr=0x3FE len=3 with data 0x00001..0x00004 and wr_valid continuous -> ram_we on 4 consecutive cycles at 0x3FE,0x3FF,0x000,0x001; done pulses once; busy low afterwards.
3. Read full rate: read cmd addr=0x3FE len=3, rd_ready=1 -> rd_valid rises 2 edges after the command handshake; rd_data 0x00001,0x00002,0x00003,0x00004 on 4 consecutive cycles; then done.
4. Read backpressure: read addr=0 len=15 over preloaded words k+0x100, with rd_ready toggling pseudo-randomly -> exactly 16 accepted words 0x100..0x10F in order; rd_data held while stalled; FIFO never exceeds 2.
5. Single word and busy guard: read len=0 -> one word then done. A second cmd_valid during the burst -> not accepted until the done cycle.
6. Reset mid-read: assert rst_n=0 after 2 of 8 words popped -> rd_valid=0 and state IDLE. A new read afterwards returns the correct data from the start address.

Source files
------------

// File: rtl/ram_burst_controller.sv
// ram_burst_controller: burst read/write initiator for a 1-cycle-latency synchronous RAM with a 2-entry read skid FIFO
module ram_burst_controller #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
    state_t            state;
    logic [ADDR_W-1:0] base, len;
    logic [ADDR_W:0]   idx;
    logic              inflight, wp, rp, pop, issue, all_issued;
    logic [DATA_W-1:0] fifo [2];
    logic [1:0]        count;
    assign all_issued = idx > {1'b0, len};
    assign pop        = rd_valid & rd_ready;
    // issue only if the word can still find a FIFO slot once it lands
    assign issue      = state == READ && !all_issued &&
                        ({1'b0, count} + {2'b0, inflight} - {2'b0, pop}) < 3'd2;
    assign cmd_ready  = state == IDLE && rst_n;
    assign wr_ready   = state == WRITE;
    assign busy       = state != IDLE;
    assign rd_valid   = count != 2'd0;
    assign rd_data    = fifo[rp];
    assign ram_addr   = state == IDLE ? '0 : base + idx[ADDR_W-1:0];
    assign ram_data   = wr_data;
    assign ram_we     = state == WRITE && wr_valid;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            base     <= '0;
            len      <= '0;
            idx      <= '0;
            inflight <= 1'b0;
            fifo[0]  <= '0;
            fifo[1]  <= '0;
            wp       <= 1'b0;
            rp       <= 1'b0;
            count    <= 2'd0;
            done     <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= issue;
            if (inflight) begin
                fifo[wp] <= ram_q;
                wp       <= ~wp;
            end
            if (pop) rp <= ~rp;
            count <= count + {1'b0, inflight} - {1'b0, pop};
            if (issue) idx <= idx + 1'b1;
            case (state)
                IDLE: if (cmd_valid) begin
                    base  <= cmd_addr;
                    len   <= cmd_len;
                    idx   <= '0;
                    state <= cmd_write ? WRITE : READ;
                end
                WRITE: if (wr_valid) begin
                    idx <= idx + 1'b1;
                    if (idx[ADDR_W-1:0] == len) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                READ: if (all_issued && !inflight && count == 2'd1 && pop) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_burst_controller.sv
// tb_ram_burst_controller: directed scenario tests for ram_burst_controller with a behavioural RAM
module tb_ram_burst_controller;
    localparam int DW = 20, AW = 10;
    logic          clk = 1'b0, rst_n = 1'b0;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0, cmd_len = '0;
    logic          wr_valid = 1'b0, wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid, rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic          busy, done, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data, ram_q;
    logic [DW-1:0] mem [1024];
    int passed = 0, total = 0;

    ram_burst_controller #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done), .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_we(ram_we), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [AW-1:0] l);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input int n, input logic [DW-1:0] v0);
        send_cmd(1'b1, a, AW'(n - 1));
        for (int k = 0; k < n; k++) begin
            wr_valid = 1'b1; wr_data = v0 + DW'(k);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        total++; if ({cmd_ready, wr_ready, rd_valid, busy, done, ram_we} !== 6'b0 || ram_addr !== '0 || rd_data !== '0)
            $display("FAIL reset_held: flags=%b addr=%h data=%h want all 0", {cmd_ready, wr_ready, rd_valid, busy, done, ram_we}, ram_addr, rd_data); else passed++;
        rst_n = 1'b1;
        @(negedge clk); #1;
        total++; if ({cmd_ready, busy} !== 2'b10) $display("FAIL reset_release: ready,busy=%b want 10", {cmd_ready, busy}); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if ({cmd_ready, wr_ready, rd_valid, busy, done, ram_we} !== 6'b0 || ram_addr !== '0)
            $display("FAIL reset_async: flags=%b addr=%h want 0", {cmd_ready, wr_ready, rd_valid, busy, done, ram_we}, ram_addr); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        total++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready2: got %b want 1", cmd_ready); else passed++;
    endtask

    task automatic test_write_wrap();
        logic [AW-1:0] ea;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h3FE; cmd_len = 10'd3;
        #1;
        total++; if (cmd_ready !== 1'b1) $display("FAIL wr_cmd_ready: got %b want 1", cmd_ready); else passed++;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wr_valid = 1'b1; wr_data = DW'(k + 1);
            ea = 10'h3FE + AW'(k);
            #1;
            total++; if ({wr_ready, ram_we, busy, done} !== 4'b1110 || ram_addr !== ea || ram_data !== DW'(k + 1))
                $display("FAIL wr_beat%0d: flags=%b addr=%h data=%h want 1110 %h %h", k, {wr_ready, ram_we, busy, done}, ram_addr, ram_data, ea, k + 1); else passed++;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        #1;
        total++; if ({done, busy, cmd_ready, wr_ready, ram_we} !== 5'b10100) $display("FAIL wr_done: flags=%b want 10100", {done, busy, cmd_ready, wr_ready, ram_we}); else passed++;
        @(negedge clk); #1;
        total++; if ({done, busy} !== 2'b00) $display("FAIL wr_done_once: done,busy=%b want 00", {done, busy}); else passed++;
        total++; if ({mem[10'h3FE], mem[10'h3FF], mem[0], mem[1]} !== {20'h1, 20'h2, 20'h3, 20'h4})
            $display("FAIL wr_mem: got %h %h %h %h want 1 2 3 4", mem[10'h3FE], mem[10'h3FF], mem[0], mem[1]); else passed++;
    endtask

    task automatic test_read_full();
        rd_ready = 1'b1;
        send_cmd(1'b0, 10'h3FE, 10'd3);
        #1;
        total++; if ({rd_valid, busy} !== 2'b01 || ram_addr !== 10'h3FE) $display("FAIL rf_issue: valid,busy=%b addr=%h want 01 3fe", {rd_valid, busy}, ram_addr); else passed++;
        @(negedge clk); #1;
        total++; if (rd_valid !== 1'b0) $display("FAIL rf_latency: rd_valid=%b want 0", rd_valid); else passed++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            total++; if (rd_valid !== 1'b1 || rd_data !== DW'(k + 1)) $display("FAIL rf_word%0d: valid=%b data=%h want 1 %h", k, rd_valid, rd_data, k + 1); else passed++;
        end
        @(negedge clk); #1;
        total++; if ({done, rd_valid, busy, cmd_ready} !== 4'b1001) $display("FAIL rf_done: flags=%b want 1001", {done, rd_valid, busy, cmd_ready}); else passed++;
        rd_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [15:0] pat = 16'b1011_0010_1110_0101;
        logic held = 1'b0, seen = 1'b0;
        logic [DW-1:0] held_data = '0;
        int n = 0;
        do_write(10'h0, 16, 20'h100);
        send_cmd(1'b0, 10'h0, 10'd15);
        for (int c = 0; c < 300; c++) begin
            rd_ready = pat[c % 16];
            #1;
            if (held) begin
                total++; if (rd_valid !== 1'b1 || rd_data !== held_data) $display("FAIL bp_hold: valid=%b data=%h want 1 %h", rd_valid, rd_data, held_data); else passed++;
            end
            if (rd_valid && rd_ready) begin
                total++; if (rd_data !== 20'h100 + DW'(n)) $display("FAIL bp_word%0d: got %h want %h", n, rd_data, 20'h100 + n); else passed++;
                n++;
            end
            held = rd_valid && !rd_ready;
            held_data = rd_data;
            if (done) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        total++; if (!seen || n != 16) $display("FAIL bp_count: done=%b words=%0d want 1 16", seen, n); else passed++;
        rd_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_busy();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'd5; cmd_len = 10'd0; rd_ready = 1'b1;
        @(negedge clk);
        cmd_addr = 10'd0;
        #1;
        total++; if ({cmd_ready, busy} !== 2'b01) $display("FAIL sb_guard1: ready,busy=%b want 01", {cmd_ready, busy}); else passed++;
        @(negedge clk); #1;
        total++; if (cmd_ready !== 1'b0) $display("FAIL sb_guard2: ready=%b want 0", cmd_ready); else passed++;
        @(negedge clk); #1;
        total++; if ({rd_valid, cmd_ready} !== 2'b10 || rd_data !== 20'h105) $display("FAIL sb_word: valid,ready=%b data=%h want 10 00105", {rd_valid, cmd_ready}, rd_data); else passed++;
        @(negedge clk); #1;
        total++; if ({done, cmd_ready, busy, rd_valid} !== 4'b1100) $display("FAIL sb_done: flags=%b want 1100", {done, cmd_ready, busy, rd_valid}); else passed++;
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        total++; if ({busy, done} !== 2'b10) $display("FAIL sb_accept2: busy,done=%b want 10", {busy, done}); else passed++;
        repeat (2) @(negedge clk);
        #1;
        total++; if (rd_valid !== 1'b1 || rd_data !== 20'h100) $display("FAIL sb_word2: valid=%b data=%h want 1 00100", rd_valid, rd_data); else passed++;
        @(negedge clk); #1;
        total++; if ({done, rd_valid} !== 2'b10) $display("FAIL sb_done2: done,valid=%b want 10", {done, rd_valid}); else passed++;
        rd_ready = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        rd_ready = 1'b1;
        send_cmd(1'b0, 10'h0, 10'd7);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            total++; if (rd_valid !== 1'b1 || rd_data !== 20'h100 + DW'(k)) $display("FAIL rr_pre%0d: valid=%b data=%h want 1 %h", k, rd_valid, rd_data, 20'h100 + k); else passed++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if ({rd_valid, busy, cmd_ready, done} !== 4'b0 || rd_data !== '0) $display("FAIL rr_reset: flags=%b data=%h want 0000 0", {rd_valid, busy, cmd_ready, done}, rd_data); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        send_cmd(1'b0, 10'h0, 10'd1);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            total++; if (rd_valid !== 1'b1 || rd_data !== 20'h100 + DW'(k)) $display("FAIL rr_post%0d: valid=%b data=%h want 1 %h", k, rd_valid, rd_data, 20'h100 + k); else passed++;
        end
        @(negedge clk); #1;
        total++; if ({done, rd_valid, busy} !== 3'b100) $display("FAIL rr_done: flags=%b want 100", {done, rd_valid, busy}); else passed++;
        rd_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_wrap();
        test_read_full();
        test_backpressure();
        test_single_busy();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", passed, total);
        $fatal(1);
    end
endmodule
